// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters, bursts of up to BURST_LEN beats.
// Define FIFO_ARB_PRIO_EN to make requester 0 urgent at arbitration time (never pre-empts a running burst).
//
// state | meaning
// IDLE  | no grant; arbitrate among valid requesters, one bubble cycle
// BURST | grant_id owns the write port until BURST_LEN beats or its valid drops
module fifo_wr_arbiter #(
   parameter int WIDTH     = 8,
   parameter int NUM_REQ   = 4,
   parameter int BURST_LEN = 4,
   parameter int ID_W      = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic                     fifo_full,
   output logic                     fifo_wr_en,
   output logic [WIDTH-1:0]         fifo_wr_data,
   output logic                     grant_valid,
   output logic [ID_W-1:0]          grant_id
);

   localparam int CNT_W = $clog2(BURST_LEN + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t            state, state_nx;
   logic [ID_W-1:0]   grant_id_nx;
   logic              grant_valid_nx;
   logic [CNT_W-1:0]  beat_cnt, beat_cnt_nx;
   logic [ID_W-1:0]   last_grant, last_grant_nx;

   logic              port_open;
   logic              gnt_req_valid;
   logic              xfer;
   logic              any_valid;
   logic [ID_W-1:0]   winner;
   logic              urgent;
   int                best_off;
   int                off;

   // Write port mux; reset forces the port closed so an aborted burst never writes.
   always_comb begin
      gnt_req_valid = 1'b0;
      fifo_wr_data  = '0;
      port_open     = reset && (state == BURST) && !fifo_full;
      req_ready     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == ID_W'(i)) begin
            gnt_req_valid = req_valid[i];
            fifo_wr_data  = req_data[i*WIDTH +: WIDTH];
            req_ready[i]  = port_open;
         end
      end
      xfer       = port_open && gnt_req_valid;
      fifo_wr_en = xfer;
   end

   // Round-robin pick: smallest distance past last_grant, wrapping modulo NUM_REQ.
   always_comb begin
      any_valid = |req_valid;
      winner    = '0;
      urgent    = 1'b0;
      best_off  = NUM_REQ;
      off       = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         off = (i + 2*NUM_REQ - 1 - int'(last_grant)) % NUM_REQ;
         if (req_valid[i] && (off < best_off)) begin
            best_off = off;
            winner   = ID_W'(i);
         end
      end
`ifdef FIFO_ARB_PRIO_EN
      if (req_valid[0]) begin
         winner = '0;
         urgent = 1'b1;
      end
`endif
   end

   always_comb begin
      state_nx      = state;
      grant_id_nx   = grant_id;
      beat_cnt_nx   = beat_cnt;
      last_grant_nx = last_grant;
      case (state)
         IDLE: begin
            if (any_valid) begin
               state_nx    = BURST;
               grant_id_nx = winner;
               beat_cnt_nx = '0;
               // urgent grants leave the pointer alone so the others keep their turn order
               if (!urgent) last_grant_nx = winner;
            end
         end
         BURST: begin
            if (xfer) begin
               beat_cnt_nx = beat_cnt + CNT_W'(1);
               if (beat_cnt == CNT_W'(BURST_LEN - 1)) state_nx = IDLE;
            end else if (!gnt_req_valid) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      grant_valid_nx = (state_nx == BURST);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         grant_valid <= 1'b0;
         grant_id    <= '0;
         beat_cnt    <= '0;
         last_grant  <= ID_W'(NUM_REQ - 1);
      end else begin
         state       <= state_nx;
         grant_valid <= grant_valid_nx;
         grant_id    <= grant_id_nx;
         beat_cnt    <= beat_cnt_nx;
         last_grant  <= last_grant_nx;
      end
   end

endmodule
